// File: rtl/wb_data_resize_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_data_resize_seq_pkg
// Purpose  : Shared encodings for the sequenced 32-to-8 bit Wishbone resizer:
//            FSM states, master response type and classic-cycle constants.
// Revision : 1.0 - initial release
// ============================================================================
package wb_data_resize_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RSP_ACK = 2'd0,
    RSP_ERR = 2'd1,
    RSP_RTY = 2'd2
  } resp_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  // Resolve simultaneous slave terminations: err beats rty beats ack.
  function automatic resp_t resp_select(input logic i_err, input logic i_rty);
    resp_t v_resp;
    if (i_err) begin
      v_resp = RSP_ERR;
    end else if (i_rty) begin
      v_resp = RSP_RTY;
    end else begin
      v_resp = RSP_ACK;
    end
    return v_resp;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_data_resize_seq_lane_sel.sv
`default_nettype none
// ============================================================================
// Module   : wb_lane_sel
// Purpose  : Picks the highest pending byte lane and maps it to the byte
//            offset on the 8-bit slave bus for the configured endianness.
// Revision : 1.0 - initial release
// ============================================================================
module wb_lane_sel #(
  parameter string endian = "big"
) (
  input  logic [3:0] i_pending,
  output logic [1:0] o_lane,
  output logic [1:0] o_offset
);

  // Priority encoder: the last (highest) set bit wins.
  always_comb begin
    o_lane = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (i_pending[i]) begin
        o_lane = 2'(i);
      end
    end
  end

  generate
    if (endian == "little") begin : g_little
      assign o_offset = o_lane;
    end else begin : g_big
      // Big endian: the most significant lane lives at the lowest address.
      assign o_offset = 2'd3 - o_lane;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/wb_data_resize_seq.sv
`default_nettype none
// ============================================================================
// Module   : wb_data_resize_seq
// Purpose  : Sequenced width converter from a 32-bit Wishbone master to an
//            8-bit Wishbone slave. Each selected byte lane becomes one classic
//            slave access; read bytes are gathered into one 32-bit word and
//            the master sees a single ack/err/rty pulse at the end.
// Options  : define WB_DATA_RESIZE_SEQ_TIMEOUT_EN to add a slave response
//            watchdog that ends a stalled access with an error after
//            timeout_cycles idle ACCESS cycles.
// Revision : 1.0 - initial release
// ============================================================================
module wb_data_resize_seq
  import wb_data_resize_seq_pkg::*;
#(
  parameter int    aw             = 32,
  parameter int    mdw            = 32,
  parameter int    sdw            = 8,
  parameter string endian         = "big",
  parameter int    timeout_cycles = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [aw-1:0]   wbm_adr_i,
  input  logic [mdw-1:0]  wbm_dat_i,
  input  logic [3:0]      wbm_sel_i,
  input  logic            wbm_we_i,
  input  logic            wbm_cyc_i,
  input  logic            wbm_stb_i,
  input  logic [2:0]      wbm_cti_i,
  input  logic [1:0]      wbm_bte_i,
  output logic [mdw-1:0]  wbm_dat_o,
  output logic            wbm_ack_o,
  output logic            wbm_err_o,
  output logic            wbm_rty_o,
  output logic [aw-1:0]   wbs_adr_o,
  output logic [sdw-1:0]  wbs_dat_o,
  output logic            wbs_we_o,
  output logic            wbs_cyc_o,
  output logic            wbs_stb_o,
  output logic [2:0]      wbs_cti_o,
  output logic [1:0]      wbs_bte_o,
  input  logic [sdw-1:0]  wbs_dat_i,
  input  logic            wbs_ack_i,
  input  logic            wbs_err_i,
  input  logic            wbs_rty_i
);

  // Watchdog counter is at least 8 bits, wider if the limit needs it.
  localparam int c_tmo_w = ($clog2(timeout_cycles + 1) > 8) ? $clog2(timeout_cycles + 1) : 8;
  localparam logic [c_tmo_w-1:0] c_tmo_limit = c_tmo_w'(timeout_cycles);

  state_t           r_state;
  logic [3:0]       r_pending;
  logic [mdw-1:0]   r_data;
  logic             r_cyc;
  logic             r_stb;
  logic             r_ack;
  logic             r_err;
  logic             r_rty;
`ifdef WB_DATA_RESIZE_SEQ_TIMEOUT_EN
  logic [c_tmo_w-1:0] r_tmo;
`endif

  logic [1:0]       w_lane;
  logic [1:0]       w_offset;
  logic [3:0]       w_pending_next;
  logic             w_term;
  resp_t            w_resp;
  logic             w_unused;

  wb_lane_sel #(
    .endian (endian)
  ) u_lane_sel (
    .i_pending (r_pending),
    .o_lane    (w_lane),
    .o_offset  (w_offset)
  );

  assign w_pending_next = r_pending & ~(4'b0001 << w_lane);
  assign w_term         = wbs_ack_i | wbs_err_i | wbs_rty_i;
  assign w_resp         = resp_select(wbs_err_i, wbs_rty_i);

  // Address bits [1:0] come from the lane; cti/bte are not forwarded.
`ifdef WB_DATA_RESIZE_SEQ_TIMEOUT_EN
  assign w_unused = ^{wbm_cti_i, wbm_bte_i, wbm_adr_i[1:0]};
`else
  assign w_unused = ^{wbm_cti_i, wbm_bte_i, wbm_adr_i[1:0], c_tmo_limit};
`endif

  assign wbs_adr_o = {wbm_adr_i[aw-1:2], w_offset};
  assign wbs_dat_o = wbm_dat_i[{w_lane, 3'b000} +: sdw];
  assign wbs_we_o  = wbm_we_i & r_cyc;
  assign wbs_cyc_o = r_cyc;
  assign wbs_stb_o = r_stb;
  assign wbs_cti_o = CTI_CLASSIC;
  assign wbs_bte_o = BTE_LINEAR;

  assign wbm_dat_o = r_data;
  assign wbm_ack_o = r_ack;
  assign wbm_err_o = r_err;
  assign wbm_rty_o = r_rty;

  // Sequencer: accept a master request, walk the selected lanes, respond once.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state   <= ST_IDLE;
      r_pending <= '0;
      r_data    <= '0;
      r_cyc     <= 1'b0;
      r_stb     <= 1'b0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_rty     <= 1'b0;
`ifdef WB_DATA_RESIZE_SEQ_TIMEOUT_EN
      r_tmo     <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (wbm_cyc_i && wbm_stb_i) begin
            r_data <= '0;
            if (wbm_sel_i != 4'b0000) begin
              r_pending <= wbm_sel_i;
              r_cyc     <= 1'b1;
              r_stb     <= 1'b1;
`ifdef WB_DATA_RESIZE_SEQ_TIMEOUT_EN
              r_tmo     <= '0;
`endif
              r_state   <= ST_ACCESS;
            end else begin
              // Nothing selected: acknowledge without touching the slave.
              r_ack   <= 1'b1;
              r_state <= ST_RESP;
            end
          end
        end

        ST_ACCESS: begin
          if (!wbm_cyc_i) begin
            // Master abandoned the cycle: quietly release the slave bus.
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
            r_pending <= '0;
            r_state   <= ST_IDLE;
          end else if (w_term) begin
            if (w_resp != RSP_ACK) begin
              r_cyc     <= 1'b0;
              r_stb     <= 1'b0;
              r_pending <= '0;
              r_err     <= (w_resp == RSP_ERR);
              r_rty     <= (w_resp == RSP_RTY);
              r_state   <= ST_RESP;
            end else begin
              if (!wbm_we_i) begin
                r_data[{w_lane, 3'b000} +: sdw] <= wbs_dat_i;
              end
              r_pending <= w_pending_next;
`ifdef WB_DATA_RESIZE_SEQ_TIMEOUT_EN
              r_tmo     <= '0;
`endif
              if (w_pending_next == 4'b0000) begin
                r_cyc   <= 1'b0;
                r_stb   <= 1'b0;
                r_ack   <= 1'b1;
                r_state <= ST_RESP;
              end
            end
          end else begin
`ifdef WB_DATA_RESIZE_SEQ_TIMEOUT_EN
            if (r_tmo == c_tmo_limit) begin
              r_cyc     <= 1'b0;
              r_stb     <= 1'b0;
              r_pending <= '0;
              r_err     <= 1'b1;
              r_state   <= ST_RESP;
            end else begin
              r_tmo <= r_tmo + 1'b1;
            end
`endif
          end
        end

        ST_RESP: begin
          r_ack     <= 1'b0;
          r_err     <= 1'b0;
          r_rty     <= 1'b0;
          r_pending <= '0;
          r_state   <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/wb_data_resize_seq.md
Name: wb_data_resize_seq

Overview:
Sequenced width converter between a 32-bit Wishbone master and an 8-bit Wishbone slave. Each master access is split into one classic slave access per asserted wbm_sel_i bit. Read bytes are gathered into a 32-bit word. The master receives a single ack, err or rty when the sequence ends. It sits in the same position as the combinational resizer, but it supports multi-byte selects (half-word and word) on byte-wide peripherals.

Parameters:
aw, 32, address width
mdw, 32, master data width; only 32 supported
sdw, 8, slave data width; only 8 supported
endian, "big", byte-lane to address mapping: "big" maps lane 3 to offset 0; "little" maps lane n to offset n
timeout_cycles, 255, slave response watchdog limit; used only with the optional feature

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  asynchronous active-high reset
wbm_adr_i  in  aw  master address; bits [1:0] ignored
wbm_dat_i  in  32  master write data
wbm_sel_i  in  4  master byte selects
wbm_we_i  in  1  write enable
wbm_cyc_i  in  1  cycle
wbm_stb_i  in  1  strobe
wbm_cti_i  in  3  cycle type; ignored
wbm_bte_i  in  2  burst type; ignored
wbm_dat_o  out  32  assembled read data
wbm_ack_o  out  1  single-cycle ack pulse
wbm_err_o  out  1  single-cycle error pulse
wbm_rty_o  out  1  single-cycle retry pulse
wbs_adr_o  out  aw  {wbm_adr_i[aw-1:2], lane offset}
wbs_dat_o  out  8  write byte of the current lane
wbs_we_o  out  1  copy of wbm_we_i while active
wbs_cyc_o  out  1  registered slave cycle
wbs_stb_o  out  1  registered slave strobe
wbs_cti_o  out  3  constant 3'b000 (classic)
wbs_bte_o  out  2  constant 2'b00
wbs_dat_i  in  8  slave read byte
wbs_ack_i  in  1  slave ack
wbs_err_i  in  1  slave error
wbs_rty_i  in  1  slave retry

Behaviour:
- Clock, reset: one clock, wb_clk_i. Reset wb_rst_i is asynchronous and active-high.
- Reset values: state IDLE; wbs_cyc_o, wbs_stb_o, wbm_ack_o, wbm_err_o, wbm_rty_o all 0; data register 0; pending mask 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - On wbm_cyc_i & wbm_stb_i with sel != 0: latch pending = wbm_sel_i and clear the data register. Next state ACCESS; wbs_cyc_o and wbs_stb_o go to 1 in the next cycle.
  - On wbm_cyc_i & wbm_stb_i with sel == 0: go to RESP with no slave access; wbm_ack_o pulses and wbm_dat_o = 0.
- ACCESS:
  - Current lane = highest set bit of pending.
  - wbs_adr_o[1:0] = lane offset per endian. wbs_dat_o = that lane's byte of wbm_dat_i.
  - On wbs_ack_i: on a read, store wbs_dat_i into that lane of the data register, then clear the lane's pending bit. If other pending bits remain, stay in ACCESS with stb held high; the next lane is presented in the following cycle. If none remain, drop cyc/stb and go to RESP with the ack flag set.
  - On wbs_err_i or wbs_rty_i: abandon the remaining lanes, drop cyc/stb, go to RESP with the err or rty flag. Priority: err > rty > ack if asserted together.
  - If the master drops wbm_cyc_i: drop cyc/stb and go to IDLE with no response.
- RESP: exactly one of wbm_ack_o, wbm_err_o, wbm_rty_o is 1 for one cycle; then go to IDLE.
- Latency: a master request sampled in cycle 0 gives the first slave stb in cycle 1. The master response comes 1 cycle after the final slave termination. With a zero-wait-state slave, latency is N+1 cycles for N selected lanes.
- wbm_dat_o holds the data register. Unwritten lanes read 0. The register is valid during the response pulse and held until the next request.
- Master signals must stay stable until the response (Wishbone classic). A new request is accepted in the cycle after RESP.

Optional Feature:
- WB_DATA_RESIZE_SEQ_TIMEOUT_EN defined:
  - An 8-bit-or-wider counter clears on every lane start and increments each ACCESS cycle without slave termination.
  - At timeout_cycles it drops cyc/stb and goes to RESP with wbm_err_o.
- Undefined: no counter; ACCESS waits indefinitely.

Decomposition:
- Package wb_data_resize_seq_pkg: state encoding (IDLE, ACCESS, RESP), response-type encoding (ACK, ERR, RTY), CTI_CLASSIC constant.
- One sub-module, wb_lane_sel: combinational priority encoder from pending mask to lane index plus lane offset per endian.

Test Plan:
- Big-endian write, adr 0x100, sel 4'b1111, dat 0xAABBCCDD, zero-wait slave -> slave writes AA@0x100, BB@0x101, CC@0x102, DD@0x103; wbm_ack_o one pulse in cycle 5.
- Big-endian read, sel 4'b1100, slave returns 0x12 then 0x34 -> slave adr offsets 0 then 1; wbm_dat_o 0x12340000; single ack.
- Little-endian read, sel 4'b0001, slave returns 0x5A after 3 wait states -> wbs_adr_o[1:0] = 0; wbm_dat_o 0x0000005A; ack 1 cycle after slave ack.
- Error mid-sequence, sel 4'b1111, wbs_err_i on the second lane -> no third access; wbm_err_o one pulse; no wbm_ack_o.
- sel 4'b0000 -> no wbs_stb_o; wbm_ack_o after 1 cycle; wbm_dat_o 0.
- Async reset asserted during ACCESS -> wbs_cyc_o/wbs_stb_o go to 0 immediately. With WB_DATA_RESIZE_SEQ_TIMEOUT_EN and timeout_cycles 4, a silent slave gives wbm_err_o 5 cycles after stb.
